fix_tx_trailer: RTL and testbench



---
 rtl/fix_tx_trailer.sv | 179 +++++++++++++++++
 tb/tb_fix_tx_trailer.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fix_tx_trailer.sv
// fix_tx_trailer: transmit-side FIX framing stage.
// Passes message bytes straight through and keeps a mod-256 byte sum.
// After the last body byte it appends the trailer "10=ddd<SOH>".
// Optional build macro FIX_TX_MSG_COUNT_EN adds msg_count_o, a count of completed messages.
module fix_tx_trailer #(
    parameter logic [7:0] SOH_CHAR = 8'h01,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy_o,
    output logic [7:0]       cksum_o,
    output logic             cksum_valid_o
`ifdef FIX_TX_MSG_COUNT_EN
    ,
    output logic [CNT_W-1:0] msg_count_o
`endif
);

    typedef enum logic [2:0] {BODY, T_1, T_0, T_EQ, D_H, D_T, D_O, T_SOH} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_sum;
    logic [7:0]  r_cks;
    logic        w_free;
    logic        w_accept;
    logic        w_load;
    logic        w_load_last;
    logic [7:0]  w_load_data;
    logic [11:0] w_bcd;

    // Split an 8-bit value into hundreds/tens/ones digits using constant compares only.
    function automatic logic [11:0] f_bcd3(input logic [7:0] v);
        logic [7:0] rem;
        logic [3:0] h;
        logic [3:0] t;
        h = 4'd0;
        if (v >= 8'd200)
            h = 4'd2;
        else if (v >= 8'd100)
            h = 4'd1;
        rem = v - ((h == 4'd2) ? 8'd200 : ((h == 4'd1) ? 8'd100 : 8'd0));
        t = 4'd0;
        for (int k = 1; k < 10; k++)
            if (rem >= 8'(k * 10))
                t = 4'(k);
        rem = rem - ({4'd0, t} * 8'd10);
        return {h, t, rem[3:0]};
    endfunction

    assign w_free = !out_valid || out_ready;
    assign w_bcd  = f_bcd3(r_cks);

    // Next-state and output-register load selection; in_ready never looks at in_valid.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_data = 8'h00;
        w_load_last = 1'b0;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        busy_o      = 1'b1;
        case (r_state)
            BODY: begin
                busy_o      = 1'b0;
                in_ready    = w_free;
                w_accept    = in_valid && w_free;
                w_load      = w_accept;
                w_load_data = in_data;
                if (w_accept && in_last)
                    w_state_nxt = T_1;
            end
            T_1: begin
                w_load      = w_free;
                w_load_data = 8'h31;
                if (w_free) w_state_nxt = T_0;
            end
            T_0: begin
                w_load      = w_free;
                w_load_data = 8'h30;
                if (w_free) w_state_nxt = T_EQ;
            end
            T_EQ: begin
                w_load      = w_free;
                w_load_data = 8'h3D;
                if (w_free) w_state_nxt = D_H;
            end
            D_H: begin
                w_load      = w_free;
                w_load_data = 8'h30 + {4'h0, w_bcd[11:8]};
                if (w_free) w_state_nxt = D_T;
            end
            D_T: begin
                w_load      = w_free;
                w_load_data = 8'h30 + {4'h0, w_bcd[7:4]};
                if (w_free) w_state_nxt = D_O;
            end
            D_O: begin
                w_load      = w_free;
                w_load_data = 8'h30 + {4'h0, w_bcd[3:0]};
                if (w_free) w_state_nxt = T_SOH;
            end
            T_SOH: begin
                w_load      = w_free;
                w_load_data = SOH_CHAR;
                w_load_last = 1'b1;
                if (w_free) w_state_nxt = BODY;
            end
            default: w_state_nxt = BODY;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= BODY;
        else
            r_state <= w_state_nxt;
    end

    // Single output register: load when free, otherwise hold until downstream takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            out_data  <= w_load_data;
            out_last  <= w_load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Running byte sum, latched checksum and its one-cycle update pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum         <= 8'h00;
            r_cks         <= 8'h00;
            cksum_o       <= 8'h00;
            cksum_valid_o <= 1'b0;
        end else begin
            cksum_valid_o <= 1'b0;
            if (w_accept) begin
                r_sum <= r_sum + in_data;
                if (in_last) begin
                    r_cks         <= r_sum + in_data;
                    cksum_o       <= r_sum + in_data;
                    cksum_valid_o <= 1'b1;
                end
            end else if ((r_state == T_SOH) && w_free) begin
                r_sum <= 8'h00;
            end
        end
    end

`ifdef FIX_TX_MSG_COUNT_EN
    // Completed-message counter, bumped when the closing SOH leaves the block.
    always_ff @(posedge clk) begin
        if (rst)
            msg_count_o <= '0;
        else if (out_valid && out_ready && out_last)
            msg_count_o <= msg_count_o + 1'b1;
    end
`else
    // Message counter not built in this configuration.
`endif

endmodule

// File: tb/tb_fix_tx_trailer.sv
// Testbench for fix_tx_trailer: randomized and directed messages checked
// against a queue-based model of "body bytes followed by 10=ddd<SOH>".
module tb_fix_tx_trailer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;
    logic       busy_o;
    logic [7:0] cksum_o;
    logic       cksum_valid_o;
`ifdef FIX_TX_MSG_COUNT_EN
    logic [15:0] msg_count_o;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0] got_q[$];
    int         got_cyc[$];
    bit         got_rdy[$];
    bit         got_busy[$];
    int         acc_cyc[$];
    int         ck_cnt = 0;
    logic [7:0] ck_val = 8'h00;

    logic [8:0] exp_q[$];
    logic [7:0] stim_d[$];
    bit         stim_l[$];

    bit rdy_rand = 1'b0;
    bit rdy_man  = 1'b1;
    bit rnd_bit  = 1'b1;

    assign out_ready = rdy_rand ? rnd_bit : rdy_man;

    fix_tx_trailer dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_last      (out_last),
        .out_ready     (out_ready),
        .busy_o        (busy_o),
        .cksum_o       (cksum_o),
        .cksum_valid_o (cksum_valid_o)
`ifdef FIX_TX_MSG_COUNT_EN
        ,
        .msg_count_o   (msg_count_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = ($urandom_range(0, 3) != 0);
    end

    // Passive monitor: records transfers midway between active edges.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                got_cyc.push_back(cyc);
                got_rdy.push_back(in_ready);
                got_busy.push_back(busy_o);
            end
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (cksum_valid_o) begin
                ck_cnt = ck_cnt + 1;
                ck_val = cksum_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        got_q.delete(); got_cyc.delete(); got_rdy.delete(); got_busy.delete();
        acc_cyc.delete(); exp_q.delete(); stim_d.delete(); stim_l.delete();
    endtask

    // Model: the message unchanged, then "10=" + three decimal digits of sum mod 256 + SOH.
    function automatic void add_msg(input logic [7:0] m[$]);
        int s = 0;
        foreach (m[i]) begin
            stim_d.push_back(m[i]);
            stim_l.push_back(i == m.size() - 1);
            exp_q.push_back({1'b0, m[i]});
            s = s + int'(m[i]);
        end
        s = s % 256;
        exp_q.push_back({1'b0, 8'h31});
        exp_q.push_back({1'b0, 8'h30});
        exp_q.push_back({1'b0, 8'h3D});
        exp_q.push_back({1'b0, 8'(48 + s / 100)});
        exp_q.push_back({1'b0, 8'(48 + (s / 10) % 10)});
        exp_q.push_back({1'b0, 8'(48 + s % 10)});
        exp_q.push_back({1'b1, 8'h01});
    endfunction

    task automatic drive(input bit gaps);
        int n;
        bit acc;
        foreach (stim_d[i]) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            in_valid = 1'b1;
            in_data  = stim_d[i];
            in_last  = stim_l[i];
            n = 0;
            acc = 1'b0;
            while (!acc && n < 500) begin
                @(negedge clk);
                acc = in_ready;
                tick();
                n++;
            end
            if (!acc) begin
                checks++; failures++;
                $display("FAIL accept_timeout byte %0d in_ready=%0b required=1", i, in_ready);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (got_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        checks++;
        if (got_q.size() < n) begin
            failures++;
            $display("FAIL out_timeout got=%0d bytes required=%0d", got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        checks++;
        if ({out_valid, out_data, out_last, busy_o, cksum_o, cksum_valid_o} !== 19'h0) begin
            failures++;
            $display("FAIL reset_outputs got v=%0b d=%h l=%0b busy=%0b ck=%h ckv=%0b required all 0",
                     out_valid, out_data, out_last, busy_o, cksum_o, cksum_valid_o);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%0b required=1", in_ready);
        end
`ifdef FIX_TX_MSG_COUNT_EN
        checks++;
        if (msg_count_o !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d required=0", msg_count_o);
        end
`endif
    endtask

    task automatic test_single_byte();
        logic [7:0] m[$];
        int ck0;
        clear_all();
        ck0 = ck_cnt;
        m.push_back(8'h41);
        add_msg(m);
        drive(1'b0);
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL single_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        checks++;
        if (ck_cnt - ck0 != 1) begin
            failures++;
            $display("FAIL single_ck_pulses got=%0d required=1", ck_cnt - ck0);
        end
        checks++;
        if (ck_val !== 8'h41 || cksum_o !== 8'h41) begin
            failures++;
            $display("FAIL single_cksum got=%h/%h required=41", ck_val, cksum_o);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] m[$];
        clear_all();
        m.push_back(8'hFF); m.push_back(8'hFF); m.push_back(8'h03);
        add_msg(m);
        drive(1'b0);
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL wrap_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        checks++;
        if (cksum_o !== 8'h01) begin
            failures++;
            $display("FAIL wrap_cksum got=%h required=01", cksum_o);
        end
    endtask

    task automatic test_trailer_timing();
        logic [7:0] m[$];
        clear_all();
        m.push_back(8'h80); m.push_back(8'h7F);
        add_msg(m);
        drive(1'b0);
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL timing_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        if (got_q.size() == 9) begin
            for (int i = 2; i <= 8; i++) begin
                checks++;
                if (got_cyc[i] != got_cyc[i-1] + 1) begin
                    failures++;
                    $display("FAIL timing_gap idx %0d cycle got=%0d required=%0d", i, got_cyc[i], got_cyc[i-1] + 1);
                end
            end
            for (int i = 1; i <= 8; i++) begin
                checks++;
                if (got_rdy[i] !== (i == 8) || got_busy[i] !== (i != 8)) begin
                    failures++;
                    $display("FAIL timing_ready idx %0d in_ready=%0b busy=%0b required in_ready=%0b busy=%0b",
                             i, got_rdy[i], got_busy[i], (i == 8), (i != 8));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] m[$];
        int k = 0;
        clear_all();
        m.push_back(8'h41);
        add_msg(m);
        drive(1'b0);
        while (!(got_q.size() == 5 && out_valid) && k < 100) begin
            tick();
            k++;
        end
        rdy_man = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h36 || out_last !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got v=%0b d=%h l=%0b required v=1 d=36 l=0",
                         c, out_valid, out_data, out_last);
            end
        end
        rdy_man = 1'b1;
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL stall_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        tick();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL stall_count got=%0d bytes required=%0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset_mid_trailer();
        logic [7:0] m[$];
        int k = 0;
        clear_all();
        m.push_back(8'h41);
        add_msg(m);
        drive(1'b0);
        while (!(got_q.size() == 5 && out_valid) && k < 100) begin
            tick();
            k++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b1 || cksum_o !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state got v=%0b busy=%0b rdy=%0b ck=%h required v=0 busy=0 rdy=1 ck=00",
                     out_valid, busy_o, in_ready, cksum_o);
        end
        clear_all();
        m.delete();
        m.push_back(8'h02);
        add_msg(m);
        drive(1'b0);
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL midrst_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[$];
        int l1, l2;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_all();
        m.push_back(8'h11); m.push_back(8'h22);
        add_msg(m); l1 = m.size();
        m.delete(); m.push_back(8'h33);
        add_msg(m); l2 = m.size();
        m.delete();
        for (int i = 0; i < 3; i++) m.push_back(8'($urandom_range(0, 255)));
        add_msg(m);
        drive(1'b0);
        wait_out(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL b2b_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        if (got_q.size() >= exp_q.size() && acc_cyc.size() >= l1 + l2 + 1) begin
            checks++;
            if (acc_cyc[l1] != got_cyc[l1 + 6]) begin
                failures++;
                $display("FAIL b2b_overlap1 accept cycle got=%0d required=%0d", acc_cyc[l1], got_cyc[l1 + 6]);
            end
            checks++;
            if (acc_cyc[l1 + l2] != got_cyc[l1 + l2 + 13]) begin
                failures++;
                $display("FAIL b2b_overlap2 accept cycle got=%0d required=%0d", acc_cyc[l1 + l2], got_cyc[l1 + l2 + 13]);
            end
        end
`ifdef FIX_TX_MSG_COUNT_EN
        tick();
        checks++;
        if (msg_count_o !== 16'd3) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=3", msg_count_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] m[$];
        int s;
        clear_all();
        rdy_rand = 1'b1;
        for (int n = 0; n < 6; n++) begin
            m.delete();
            s = 0;
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                m.push_back(8'($urandom_range(0, 255)));
                s = s + int'(m[m.size() - 1]);
            end
            add_msg(m);
        end
        drive(1'b1);
        wait_out(exp_q.size());
        rdy_rand = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_stream idx %0d got=%h required=%h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
            end
        end
        checks++;
        if (cksum_o !== 8'(s % 256)) begin
            failures++;
            $display("FAIL random_cksum got=%h required=%h", cksum_o, 8'(s % 256));
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_wrap();
        test_trailer_timing();
        test_stall();
        test_reset_mid_trailer();
        test_back_to_back();
        test_random();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
